// File: rtl/opamp_sd_readout_if.sv
// Signal bundle for the op-amp sigma-delta readout.
// The slave modport is the readout block itself; the master modport is
// whatever drives the control/comparator inputs and consumes the results.
// Handshake: result_valid is a one-cycle strobe with no back-pressure. result
// is stable from that cycle until the next strobe. ser_data is meaningful
// only while ser_frame is high.
`timescale 1ns/1ps
interface opamp_sd_readout_if #(
  parameter int OUT_W = 9
);
  logic             ena;
  logic             cmp_in;
  logic             start;
  logic             fb_out;
  logic             busy;
  logic [OUT_W-1:0] result;
  logic             result_valid;
  logic             ser_data;
  logic             ser_frame;
  logic [2:0]       dbg_state;

  modport master (
    output ena, cmp_in, start,
    input  fb_out, busy, result, result_valid, ser_data, ser_frame, dbg_state
  );

  modport slave (
    input  ena, cmp_in, start,
    output fb_out, busy, result, result_valid, ser_data, ser_frame, dbg_state
  );
endinterface

// File: rtl/opamp_sd_readout.sv
// First-order sigma-delta readout for the on-chip op-amp.
// The comparator bit is double-flopped and then registered onto fb_out. That
// register closes the modulator loop through the external integrator. A
// conversion discards SETTLE_CYC samples, then counts the ones in
// N = 2^OSR_LOG2 samples of fb_out. The count is presented in parallel on
// result and shifted out MSB first on ser_data/ser_frame.
// Optional macro OPAMP_SD_CONT_EN: continuous mode. Windows run back-to-back
// with no settle gap, and the serial frame runs alongside the next window.
// Without the macro each start gives one single-shot conversion.
// dbg_state exposes the FSM state encoding (IDLE=0 SETTLE=1 ACCUM=2 DONE=3
// SHIFT=4).
`timescale 1ns/1ps
module opamp_sd_readout #(
  parameter int OSR_LOG2   = 8,
  parameter int SETTLE_CYC = 16,
  parameter int OUT_W      = OSR_LOG2 + 1
) (
  input  logic               clk,
  input  logic               rst,
  opamp_sd_readout_if.slave  bus
);

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int SH_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_ACCUM  = 3'd2,
    S_DONE   = 3'd3,
    S_SHIFT  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_fb;

  logic [SC_W-1:0]   r_settle_cnt;
  logic [OSR_LOG2-1:0] r_win_cnt;
  logic [OUT_W-1:0]  r_acc;
  logic [OUT_W-1:0]  r_result;
  logic              r_valid;

  logic [OUT_W-1:0]  r_shift;
  logic [SH_W-1:0]   r_shift_cnt;
  logic              r_frame;

  logic              w_settle_last;
  logic              w_win_last;
  logic              w_shift_last;
  logic              w_win_done;
  logic [OUT_W-1:0]  w_acc_next;

  assign w_settle_last = (r_settle_cnt == '0);
  assign w_win_last    = (r_win_cnt == '0);
  assign w_shift_last  = r_frame && (r_shift_cnt == '0);
  // The last sample of the window is counted on the same edge that publishes the
  // result, so the accumulator is never more than one sample behind.
  assign w_acc_next    = r_acc + {{(OUT_W-1){1'b0}}, r_fb};
  // A window finishes only if ena is still high at its final edge. An abort on
  // that edge leaves the previous result untouched.
  assign w_win_done    = (r_state == S_ACCUM) && w_win_last && bus.ena;

  // Comparator synchroniser and feedback register; the loop runs in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_fb    <= 1'b0;
    end else begin
      r_sync1 <= bus.cmp_in;
      r_sync2 <= r_sync1;
      r_fb    <= bus.ena ? r_sync2 : 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; dropping ena returns to IDLE from anywhere.
  always_comb begin
    w_next_state = r_state;
    if (!bus.ena) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.start) w_next_state = S_SETTLE;
        S_SETTLE: if (w_settle_last) w_next_state = S_ACCUM;
        S_ACCUM:  if (w_win_last) w_next_state = S_DONE;
`ifdef OPAMP_SD_CONT_EN
        S_DONE:   w_next_state = S_ACCUM;
`else
        S_DONE:   w_next_state = S_SHIFT;
        S_SHIFT:  if (w_shift_last) w_next_state = S_IDLE;
`endif
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  // Settle/window counters, accumulator and published result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle_cnt <= '0;
      r_win_cnt    <= '0;
      r_acc        <= '0;
      r_result     <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.ena && bus.start) begin
            r_settle_cnt <= SC_W'(SETTLE_CYC - 1);
          end
        end
        S_SETTLE: begin
          if (w_settle_last) begin
            r_acc     <= '0;
            r_win_cnt <= '1;
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end
        S_ACCUM: begin
          r_acc     <= w_acc_next;
          r_win_cnt <= r_win_cnt - 1'b1;
          if (w_win_done) begin
            r_result <= w_acc_next;
            r_valid  <= 1'b1;
          end
        end
        S_DONE: begin
          // Prepares the next window; only used in continuous mode.
          r_acc     <= '0;
          r_win_cnt <= '1;
        end
        default: begin
        end
      endcase
    end
  end

  // Serial shifter: loaded with the result, framed for OUT_W cycles after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= '0;
      r_shift_cnt <= '0;
      r_frame     <= 1'b0;
    end else if (!bus.ena) begin
      r_frame <= 1'b0;
    end else if (w_win_done) begin
      // A new result restarts any frame still in flight.
      r_shift <= w_acc_next;
      r_frame <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_frame     <= 1'b1;
      r_shift_cnt <= SH_W'(OUT_W - 1);
    end else if (r_frame) begin
      r_shift     <= {r_shift[OUT_W-2:0], 1'b0};
      r_shift_cnt <= r_shift_cnt - 1'b1;
      if (w_shift_last) begin
        r_frame <= 1'b0;
      end
    end
  end

  assign bus.fb_out       = r_fb;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.result       = r_result;
  assign bus.result_valid = r_valid;
  assign bus.ser_frame    = r_frame;
  assign bus.ser_data     = r_frame & r_shift[OUT_W-1];
  assign bus.dbg_state    = r_state;

endmodule
